// File: rtl/writeback_queue_pkg.sv
// Shared widths and the queue entry layout for the register write-back path.
package writeback_queue_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 8;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rpoint;
    logic [DATA_W-1:0]     data;
  } wb_entry;

endpackage

// File: rtl/writeback_queue_if.sv
// Write-back request inputs and register file write port of the queue.
interface writeback_queue_if;
  import writeback_queue_pkg::*;

  logic                  aluValid;
  logic [REG_ADDR_W-1:0] aluRpoint;
  logic [DATA_W-1:0]     aluData;
  logic                  memValid;
  logic [REG_ADDR_W-1:0] memRpoint;
  logic [DATA_W-1:0]     memData;
  logic                  inReady;
  logic [REG_ADDR_W-1:0] writeRpoint;
  logic [DATA_W-1:0]     writeData;
  logic                  writeEnable;

  modport master (
    output aluValid, aluRpoint, aluData, memValid, memRpoint, memData,
    input  inReady, writeRpoint, writeData, writeEnable
  );

  modport slave (
    input  aluValid, aluRpoint, aluData, memValid, memRpoint, memData,
    output inReady, writeRpoint, writeData, writeEnable
  );

endinterface

// File: rtl/writeback_queue_fwd_match.sv
// Youngest-match search of the stored queue entries for one read pointer.
module wb_fwd_match
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry [DEPTH-1:0]         entries,
  input  logic [DEPTH-1:0]            valid,
  input  logic [$clog2(DEPTH)-1:0]    head,
  input  logic [REG_ADDR_W-1:0]       rpoint,
  output logic                        hit,
  output logic [DATA_W-1:0]           data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] idx;

  // Walk from oldest to youngest so the last match seen is the youngest one
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + AW'(k);
      if (valid[idx] && (entries[idx].rpoint == rpoint)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Ordered write-back FIFO feeding the register file, with pending/forward status.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter bit DISCARD_R0 = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  writeback_queue_if.slave           bus,
  input  logic [REG_ADDR_W-1:0]      R1point,
  input  logic [REG_ADDR_W-1:0]      R2point,
  output logic                       R1fwdValid,
  output logic [DATA_W-1:0]          R1fwdData,
  output logic                       R2fwdValid,
  output logic [DATA_W-1:0]          R2fwdData,
  output logic [NUM_REGS-1:0]        pending,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry [DEPTH-1:0] entries;
  logic [DEPTH-1:0]    valid;
  logic [AW-1:0]       head;
  logic [AW-1:0]       tail;
  logic [CW-1:0]       count_q;
  logic                overflow_q;

  logic ready;
  logic mem_req;
  logic alu_req;
  logic mem_push;
  logic alu_push;
  logic pop;
  logic drop;

  // Register 0 requests are swallowed here so they never touch count or overflow
  assign mem_req  = bus.memValid && !(DISCARD_R0 && (bus.memRpoint == '0));
  assign alu_req  = bus.aluValid && !(DISCARD_R0 && (bus.aluRpoint == '0));
  assign ready    = (count_q <= CW'(DEPTH - 2));
  assign mem_push = ready && mem_req;
  assign alu_push = ready && alu_req;
  assign drop     = !ready && (mem_req || alu_req);
  assign pop      = (count_q != '0);

  // An entry is live when its distance from head is below the occupancy
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = ({1'b0, AW'(i) - head} < count_q);
    end
  end

  // Entry storage: memory result goes first (older), ALU result right behind it
  always_ff @(posedge clk) begin
    if (rst_n && mem_push) begin
      entries[tail] <= wb_entry'({bus.memRpoint, bus.memData});
    end
    if (rst_n && alu_push) begin
      entries[mem_push ? tail + AW'(1) : tail] <= wb_entry'({bus.aluRpoint, bus.aluData});
    end
  end

  // Pointers, occupancy and sticky overflow; reset drops everything queued
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      tail    <= tail + AW'(mem_push) + AW'(alu_push);
      head    <= head + AW'(pop);
      count_q <= count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // One-hot OR of every stored destination register
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) begin
        pending[entries[i].rpoint] = 1'b1;
      end
    end
  end

  assign bus.inReady     = ready;
  assign bus.writeEnable = pop;
  assign bus.writeRpoint = pop ? entries[head].rpoint : '0;
  assign bus.writeData   = pop ? entries[head].data : '0;
  assign count           = count_q;
  assign overflow        = overflow_q;

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_r1 (
    .entries (entries),
    .valid   (valid),
    .head    (head),
    .rpoint  (R1point),
    .hit     (R1fwdValid),
    .data    (R1fwdData)
  );

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_r2 (
    .entries (entries),
    .valid   (valid),
    .head    (head),
    .rpoint  (R2point),
    .hit     (R2fwdValid),
    .data    (R2fwdData)
  );

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: the queue below mirrors stored entries.
module tb_writeback_queue;
  import writeback_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;

  writeback_queue_if bus ();

  logic [4:0]  R1point;
  logic [4:0]  R2point;
  logic        R1fwdValid;
  logic [7:0]  R1fwdData;
  logic        R2fwdValid;
  logic [7:0]  R2fwdData;
  logic [31:0] pending;
  logic [2:0]  count;
  logic        overflow;

  wb_entry    sb[$];
  logic       expOverflow;
  logic [4:0] r1Sel;
  logic [4:0] r2Sel;
  int         testsRun;
  int         testsFailed;

  writeback_queue #(.DEPTH(DEPTH), .DISCARD_R0(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .R1point    (R1point),
    .R2point    (R2point),
    .R1fwdValid (R1fwdValid),
    .R1fwdData  (R1fwdData),
    .R2fwdValid (R2fwdValid),
    .R2fwdData  (R2fwdData),
    .pending    (pending),
    .count      (count),
    .overflow   (overflow)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [8:0] fwdModel(input logic [4:0] rp);
    logic [8:0] r;
    r = '0;
    foreach (sb[i]) begin
      if (sb[i].rpoint == rp) r = {1'b1, sb[i].data};
    end
    return r;
  endfunction

  task automatic checkAll();
    logic [31:0] pend;
    logic [8:0]  f1;
    logic [8:0]  f2;
    bit          busy;
    pend = '0;
    foreach (sb[i]) pend[sb[i].rpoint] = 1'b1;
    f1   = fwdModel(R1point);
    f2   = fwdModel(R2point);
    busy = (sb.size() != 0);
    checkOutput("writeEnable", 32'(bus.writeEnable), 32'(busy));
    checkOutput("writeRpoint", 32'(bus.writeRpoint), busy ? 32'(sb[0].rpoint) : 32'd0);
    checkOutput("writeData", 32'(bus.writeData), busy ? 32'(sb[0].data) : 32'd0);
    checkOutput("count", 32'(count), 32'(sb.size()));
    checkOutput("inReady", 32'(bus.inReady), 32'(sb.size() <= DEPTH - 2));
    checkOutput("pending", pending, pend);
    checkOutput("overflow", 32'(overflow), 32'(expOverflow));
    checkOutput("R1fwdValid", 32'(R1fwdValid), 32'(f1[8]));
    checkOutput("R1fwdData", 32'(R1fwdData), 32'(f1[7:0]));
    checkOutput("R2fwdValid", 32'(R2fwdValid), 32'(f2[8]));
    checkOutput("R2fwdData", 32'(R2fwdData), 32'(f2[7:0]));
  endtask

  task automatic applyStimulus(input logic mv, input logic [4:0] mr, input logic [7:0] md,
                               input logic av, input logic [4:0] ar, input logic [7:0] ad);
    bit ready;
    bit memReq;
    bit aluReq;
    @(negedge clk);
    checkAll();
    ready  = (sb.size() <= DEPTH - 2);
    memReq = mv && (mr != 5'd0);
    aluReq = av && (ar != 5'd0);
    if (sb.size() != 0) void'(sb.pop_front());
    if (ready) begin
      if (memReq) sb.push_back(wb_entry'({mr, md}));
      if (aluReq) sb.push_back(wb_entry'({ar, ad}));
    end else if (memReq || aluReq) begin
      expOverflow = 1'b1;
    end
    rst_n         = 1'b1;
    bus.memValid  = mv;
    bus.memRpoint = mr;
    bus.memData   = md;
    bus.aluValid  = av;
    bus.aluRpoint = ar;
    bus.aluData   = ad;
    R1point       = r1Sel;
    R2point       = r2Sel;
  endtask

  task automatic resetCycle();
    @(negedge clk);
    checkAll();
    rst_n        = 1'b0;
    bus.memValid = 1'b0;
    bus.aluValid = 1'b0;
    sb.delete();
    expOverflow  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 5'd0, 8'd0, 1'b0, 5'd0, 8'd0);
  endtask

  // Directed scenarios followed by a random mix
  initial begin
    testsRun      = 0;
    testsFailed   = 0;
    expOverflow   = 1'b0;
    r1Sel         = 5'd7;
    r2Sel         = 5'd3;
    rst_n         = 1'b0;
    bus.memValid  = 1'b0;
    bus.memRpoint = '0;
    bus.memData   = '0;
    bus.aluValid  = 1'b0;
    bus.aluRpoint = '0;
    bus.aluData   = '0;
    R1point       = 5'd7;
    R2point       = 5'd3;
    repeat (2) @(posedge clk);

    applyStimulus(1'b0, 5'd0, 8'd0, 1'b1, 5'd7, 8'h2A);
    idle(3);

    r1Sel = 5'd3;
    r2Sel = 5'd7;
    applyStimulus(1'b1, 5'd3, 8'h11, 1'b1, 5'd3, 8'h22);
    idle(3);

    r1Sel = 5'd5;
    r2Sel = 5'd6;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 5'd5, 8'(i), 1'b1, 5'd6, 8'(8'h80 + i));
    end
    idle(4);
    resetCycle();
    idle(1);

    r1Sel = 5'd0;
    applyStimulus(1'b0, 5'd0, 8'd0, 1'b1, 5'd0, 8'h55);
    idle(2);

    r1Sel = 5'd9;
    r2Sel = 5'd12;
    applyStimulus(1'b1, 5'd9, 8'hA1, 1'b1, 5'd10, 8'hA2);
    applyStimulus(1'b1, 5'd11, 8'hA3, 1'b1, 5'd12, 8'hA4);
    resetCycle();
    idle(3);

    r1Sel = 5'd4;
    r2Sel = 5'd9;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, 5'd0, 8'd0, 1'b1, 5'(i), 8'(i));
    end
    idle(2);

    for (int i = 0; i < 60; i++) begin
      r1Sel = 5'($urandom_range(0, 7));
      r2Sel = 5'($urandom_range(0, 7));
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
Write-side companion to the 32x8 register file. It collects register write-back requests from the ALU and load paths into a small ordered FIFO and drains one request per cycle onto the register file write port (writeRpoint / writeData / writeEnable). It also publishes pending-write status and forwarded data for the two register read pointers, so decode can bypass or stall.

Parameters:
DEPTH, 4, FIFO entries (power of two, >= 2)
DISCARD_R0, 1, when 1, requests targeting register 0 are accepted but never stored

Ports:
clk  input  1  system clock; all state updates on posedge
rst_n  input  1  synchronous reset, active-low
aluValid  input  1  ALU write-back request
aluRpoint  input  5  ALU destination register
aluData  input  8  ALU result
memValid  input  1  load write-back request
memRpoint  input  5  load destination register
memData  input  8  load data
inReady  output  1  at least 2 free entries (count <= DEPTH-2)
writeRpoint  output  5  head destination, to register file
writeData  output  8  head data, to register file
writeEnable  output  1  head valid, to register file
R1point  input  5  decode read pointer 1
R2point  input  5  decode read pointer 2
R1fwdValid  output  1  a queued write targets R1point
R1fwdData  output  8  data of youngest queued write to R1point
R2fwdValid  output  1  as R1, for R2point
R2fwdData  output  8  as R1, for R2point
pending  output  32  bit i set when any stored entry targets register i
count  output  clog2(DEPTH)+1  stored entries
overflow  output  1  sticky: request lost because the FIFO lacked room

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n low at posedge): count=0, head/tail pointers=0, overflow=0, all entries invalid. Outputs are then writeEnable=0, writeRpoint=0, writeData=0, pending=0, fwdValid=0, fwdData=0, inReady=1.
- Reset mid-operation discards queued entries without writing them.
- Drain: when count>0, head is driven combinationally with writeEnable=1. Head pops at every posedge where count>0. The register file commits on the following negedge. When count==0, writeEnable=0 and writeRpoint/writeData=0.
- Latency: a request accepted at edge N into an empty queue appears on the write port during cycle N+1 and pops at edge N+1.
- Enqueue: on a posedge with inReady=1, each valid source pushes one entry. When both sources are valid, memory is enqueued first (older) and ALU second; the ALU entry is younger.
- Pushes and a pop in the same cycle are legal: count_next = count + pushes - pop.
- Register 0 with DISCARD_R0=1: the request is accepted, not stored, and has no effect on count or overflow.
- Overflow: a valid request while inReady=0 is dropped and sets overflow. overflow clears only on reset. The other source in the same cycle is also dropped, with no partial accept.
- Forwarding: combinational search over stored entries only; same-cycle inputs are not visible. The youngest matching entry wins. The entry being popped this cycle is still visible.
- pending: OR over stored entries of a one-hot decode of each entry's Rpoint.
- Pointers wrap modulo DEPTH; full is count==DEPTH.

Decomposition:
- Shared package holds REG_ADDR_W=5, DATA_W=8, NUM_REGS=32, and a wb_entry struct {rpoint, data}.
- One sub-module, wb_fwd_match: given the entry array, valid mask, head index and a read pointer, it returns {hit, data} for the youngest match. It is instantiated twice, once each for R1 and R2.

Test Plan:
- Single write: aluValid with Rpoint=7, data=0x2A at edge 1 -> cycle 2 shows writeEnable=1, writeRpoint=7, writeData=0x2A; pending[7]=1 in cycle 2 and 0 in cycle 3; count returns to 0.
- Dual push ordering: memValid r3=0x11 and aluValid r3=0x22 in the same cycle -> write port shows 0x11 then 0x22. While both are stored, R1point=3 gives R1fwdValid=1 and R1fwdData=0x22.
- Backpressure: stall the drain path by filling with dual pushes every cycle -> inReady drops at count>=3. A push at count=3 sets overflow=1 and leaves count unchanged by that push. overflow stays 1 until rst_n is low.
- Register 0 discard: aluValid r0=0x55 -> no write-port activity, count stays 0, pending[0]=0.
- Reset mid-operation: 3 entries queued, then rst_n low for one edge -> next cycle count=0, writeEnable=0, pending=0, and no queued data reaches the write port.
- Wrap-around: 10 sequential single pushes to r1..r10 with data=index -> writes emerge in order 1..10 with matching data, with no loss across pointer wrap.
